// File: rtl/vga_pattern_gen.sv
// VGA timing and test-pattern generator: pixel-tick divider, h/v counters and
// one registered output stage carrying RGB, syncs, enable and coordinates.
module vga_pattern_gen #(
  parameter int CLK_DIV    = 2,
  parameter int COLOR_BITS = 3,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [1:0]                mode,
  input  logic [3*COLOR_BITS-1:0]   fg_color,
  output logic [3*COLOR_BITS-1:0]   RGB,
  output logic                      hsync,
  output logic                      vsync,
  output logic                      video_enable,
  output logic [9:0]                pixel_x,
  output logic [9:0]                pixel_y,
  output logic                      frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BW      = H_ACTIVE / 8;
  localparam int CW      = 3 * COLOR_BITS;

  localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  S_LAST   = 10'(H_ACTIVE - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  // Bar index by comparison against multiples of the bar width.
  function automatic logic [CW-1:0] bar_rgb(input logic [10:0] x);
    logic [2:0] b;
    b = '0;
    for (int k = 1; k < 8; k++) begin
      if (x >= 11'(k * BW)) b = 3'(k);
    end
    return {{COLOR_BITS{b[2]}}, {COLOR_BITS{b[1]}}, {COLOR_BITS{b[0]}}};
  endfunction

  logic [3:0]    div_q, div_d;
  logic [9:0]    h_cnt_q, h_cnt_d;
  logic [9:0]    v_cnt_q, v_cnt_d;
  logic [9:0]    scroll_q, scroll_d;
  logic [1:0]    mode_q, mode_d;
  logic [CW-1:0] rgb_q, rgb_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          video_enable_q, video_enable_d;
  logic [9:0]    pixel_x_q, pixel_x_d;
  logic [9:0]    pixel_y_q, pixel_y_d;
  logic          frame_start_q, frame_start_d;

  logic          tick;
  logic          h_wrap;
  logic          v_wrap;
  logic          frame_first;
  logic          active;
  logic [1:0]    mode_eff;
  logic [10:0]   h11;
  logic [10:0]   v11;
  logic [10:0]   x_sum;
  logic [10:0]   x_scr;
  logic [CW-1:0] pix;

  always_comb begin
    tick        = (div_q == DIV_LAST);
    h_wrap      = (h_cnt_q == H_LAST);
    v_wrap      = (v_cnt_q == V_LAST);
    frame_first = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
    h11         = {1'b0, h_cnt_q};
    v11         = {1'b0, v_cnt_q};
    active      = (h11 < H_ACT) && (v11 < V_ACT);

    div_d    = tick ? 4'd0 : div_q + 4'd1;
    h_cnt_d  = h_cnt_q;
    v_cnt_d  = v_cnt_q;
    scroll_d = scroll_q;
    mode_d   = mode_q;
    if (tick) begin
      h_cnt_d = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
      if (h_wrap) begin
        v_cnt_d = v_wrap ? 10'd0 : v_cnt_q + 10'd1;
        if (v_wrap) scroll_d = (scroll_q == S_LAST) ? 10'd0 : scroll_q + 10'd1;
      end
      if (frame_first) mode_d = mode;
    end

    // The (0,0) pixel already uses the mode latched on that same tick.
    mode_eff = frame_first ? mode : mode_q;

    x_sum = h11 + {1'b0, scroll_q};
    x_scr = (x_sum >= H_ACT) ? x_sum - H_ACT : x_sum;

    case (mode_eff)
      2'd0:    pix = fg_color;
      2'd1:    pix = bar_rgb(h11);
      2'd2:    pix = (h_cnt_q[5] ^ v_cnt_q[5]) ? fg_color : '0;
      default: pix = bar_rgb(x_scr);
    endcase
    if (!active) pix = '0;

    rgb_d          = rgb_q;
    hsync_d        = hsync_q;
    vsync_d        = vsync_q;
    video_enable_d = video_enable_q;
    pixel_x_d      = pixel_x_q;
    pixel_y_d      = pixel_y_q;
    frame_start_d  = tick && frame_first;
    if (tick) begin
      rgb_d          = pix;
      hsync_d        = !((h11 >= HS_START) && (h11 < HS_END));
      vsync_d        = !((v11 >= VS_START) && (v11 < VS_END));
      video_enable_d = active;
      pixel_x_d      = h_cnt_q;
      pixel_y_d      = v_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_q          <= '0;
      h_cnt_q        <= '0;
      v_cnt_q        <= '0;
      scroll_q       <= '0;
      mode_q         <= '0;
      rgb_q          <= '0;
      hsync_q        <= 1'b1;
      vsync_q        <= 1'b1;
      video_enable_q <= 1'b0;
      pixel_x_q      <= '0;
      pixel_y_q      <= '0;
      frame_start_q  <= 1'b0;
    end else begin
      div_q          <= div_d;
      h_cnt_q        <= h_cnt_d;
      v_cnt_q        <= v_cnt_d;
      scroll_q       <= scroll_d;
      mode_q         <= mode_d;
      rgb_q          <= rgb_d;
      hsync_q        <= hsync_d;
      vsync_q        <= vsync_d;
      video_enable_q <= video_enable_d;
      pixel_x_q      <= pixel_x_d;
      pixel_y_q      <= pixel_y_d;
      frame_start_q  <= frame_start_d;
    end
  end

  assign RGB          = rgb_q;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign video_enable = video_enable_q;
  assign pixel_x      = pixel_x_q;
  assign pixel_y      = pixel_y_q;
  assign frame_start  = frame_start_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench: default timing (line 0 bars/syncs), a small-timing instance for
// checkerboard, mode latch and frame period, and a tiny CLK_DIV=1 instance for scrolling.
module tb_vga_pattern_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance a: default parameters
  logic       a_rst, a_hs, a_vs, a_ve, a_fs;
  logic [1:0] a_mode;
  logic [8:0] a_fg, a_rgb;
  logic [9:0] a_px, a_py;
  vga_pattern_gen u_a (
    .clk(clk), .reset(a_rst), .mode(a_mode), .fg_color(a_fg), .RGB(a_rgb),
    .hsync(a_hs), .vsync(a_vs), .video_enable(a_ve), .pixel_x(a_px),
    .pixel_y(a_py), .frame_start(a_fs)
  );

  // Instance b: H 64/4/8/4 (80), V 40/2/2/4 (48), CLK_DIV 2 -> 7680 clk per frame
  logic       b_rst, b_hs, b_vs, b_ve, b_fs;
  logic [1:0] b_mode;
  logic [8:0] b_fg, b_rgb;
  logic [9:0] b_px, b_py;
  vga_pattern_gen #(
    .CLK_DIV(2), .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(40), .V_FP(2), .V_SYNC(2), .V_BP(4)
  ) u_b (
    .clk(clk), .reset(b_rst), .mode(b_mode), .fg_color(b_fg), .RGB(b_rgb),
    .hsync(b_hs), .vsync(b_vs), .video_enable(b_ve), .pixel_x(b_px),
    .pixel_y(b_py), .frame_start(b_fs)
  );

  // Instance c: H 8/1/1/1 (11), V 2/1/1/1 (5), CLK_DIV 1 -> 55 clk per frame, BW = 1
  logic       c_rst, c_hs, c_vs, c_ve, c_fs;
  logic [1:0] c_mode;
  logic [8:0] c_fg, c_rgb;
  logic [9:0] c_px, c_py;
  vga_pattern_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u_c (
    .clk(clk), .reset(c_rst), .mode(c_mode), .fg_color(c_fg), .RGB(c_rgb),
    .hsync(c_hs), .vsync(c_vs), .video_enable(c_ve), .pixel_x(c_px),
    .pixel_y(c_py), .frame_start(c_fs)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int b_fs_q[$];
  int c_fs_q[$];
  always @(negedge clk) begin
    if (b_fs) b_fs_q.push_back(cyc);
    if (c_fs) c_fs_q.push_back(cyc);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic goto(input bit on_c, input int x, input int y);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 8000 && !found; i++) begin
      if (on_c ? (c_px == 10'(x) && c_py == 10'(y)) : (b_px == 10'(x) && b_py == 10'(y)))
        found = 1'b1;
      else
        step(on_c ? 1 : 2);
    end
    check($sformatf("%s_reach_%0d_%0d", on_c ? "c" : "b", x, y), 32'(found), 32'd1);
  endtask

  task automatic wait_fs_c();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (c_fs) found = 1'b1;
      else step(1);
    end
    check("c_frame_start_seen", 32'(found), 32'd1);
  endtask

  logic [8:0] bar_tab [8];
  int lat, hs_first, hs_cnt, ve_cnt, vs_low, px_bad;

  initial begin
    bar_tab[0] = 9'h000; bar_tab[1] = 9'h007; bar_tab[2] = 9'h038; bar_tab[3] = 9'h03F;
    bar_tab[4] = 9'h1C0; bar_tab[5] = 9'h1C7; bar_tab[6] = 9'h1F8; bar_tab[7] = 9'h1FF;
    a_rst = 1'b0; a_mode = 2'd1; a_fg = 9'h000;
    b_rst = 1'b0; b_mode = 2'd2; b_fg = 9'h0D5;
    c_rst = 1'b0; c_mode = 2'd3; c_fg = 9'h000;

    // ---- instance a: reset hold, release latency, line 0 ----
    step(10);
    check("a_rst_rgb", 32'(a_rgb), 32'h0);
    check("a_rst_hsync", 32'(a_hs), 32'd1);
    check("a_rst_vsync", 32'(a_vs), 32'd1);
    check("a_rst_ve", 32'(a_ve), 32'd0);
    check("a_rst_fs", 32'(a_fs), 32'd0);
    check("a_rst_px", 32'(a_px), 32'd0);
    a_rst = 1'b1;
    lat = 0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      step(1);
      if (a_fs) lat = i;
    end
    check("a_fs_latency", 32'(lat), 32'd2);
    check("a_first_ve", 32'(a_ve), 32'd1);
    hs_first = -1; hs_cnt = 0; ve_cnt = 0; vs_low = 0; px_bad = 0;
    for (int p = 0; p < 800; p++) begin
      if (p > 0) step(2);
      if (a_px != 10'(p) || a_py != 10'd0) px_bad++;
      if (a_ve) ve_cnt++;
      if (!a_vs) vs_low++;
      if (!a_hs) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = p;
      end
      case (p)
        0, 79:    check($sformatf("a_bar_x%0d", p), 32'(a_rgb), 32'h000);
        80, 159:  check($sformatf("a_bar_x%0d", p), 32'(a_rgb), 32'h007);
        160, 239: check($sformatf("a_bar_x%0d", p), 32'(a_rgb), 32'h038);
        560, 639: check($sformatf("a_bar_x%0d", p), 32'(a_rgb), 32'h1FF);
        640:      check("a_bar_x640", 32'(a_rgb), 32'h000);
        default: ;
      endcase
    end
    check("a_coord_track", 32'(px_bad), 32'd0);
    check("a_hsync_start", 32'(hs_first), 32'd656);
    check("a_hsync_width", 32'(hs_cnt), 32'd96);
    check("a_ve_ticks", 32'(ve_cnt), 32'd640);
    check("a_vsync_line0", 32'(vs_low), 32'd0);
    step(2);
    check("a_line1_x", 32'(a_px), 32'd0);
    check("a_line1_y", 32'(a_py), 32'd1);

    // ---- instance b: checkerboard, syncs, mode latch, frame period ----
    step(3);
    b_rst = 1'b1;
    lat = 0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      step(1);
      if (b_fs) lat = i;
    end
    check("b_fs_latency", 32'(lat), 32'd2);
    check("b_rgb_0_0", 32'(b_rgb), 32'h000);
    goto(1'b0, 32, 0);  check("b_rgb_32_0", 32'(b_rgb), 32'h0D5);
    goto(1'b0, 67, 0);  check("b_hs_67", 32'(b_hs), 32'd1);
    goto(1'b0, 68, 0);  check("b_hs_68", 32'(b_hs), 32'd0);
    goto(1'b0, 75, 0);  check("b_hs_75", 32'(b_hs), 32'd0);
    goto(1'b0, 76, 0);  check("b_hs_76", 32'(b_hs), 32'd1);
    goto(1'b0, 0, 10);
    b_mode = 2'd0;
    goto(1'b0, 0, 32);  check("b_rgb_0_32", 32'(b_rgb), 32'h0D5);
    goto(1'b0, 32, 32); check("b_rgb_32_32", 32'(b_rgb), 32'h000);
    goto(1'b0, 0, 41);
    check("b_vs_41", 32'(b_vs), 32'd1);
    check("b_ve_41", 32'(b_ve), 32'd0);
    check("b_rgb_41", 32'(b_rgb), 32'h000);
    goto(1'b0, 0, 42);  check("b_vs_42", 32'(b_vs), 32'd0);
    goto(1'b0, 0, 43);  check("b_vs_43", 32'(b_vs), 32'd0);
    goto(1'b0, 0, 44);  check("b_vs_44", 32'(b_vs), 32'd1);
    goto(1'b0, 0, 0);
    check("b_fs_frame1", 32'(b_fs), 32'd1);
    check("b_mode0_0_0", 32'(b_rgb), 32'h0D5);
    goto(1'b0, 32, 32); check("b_mode0_32_32", 32'(b_rgb), 32'h0D5);
    goto(1'b0, 63, 39); check("b_ve_63_39", 32'(b_ve), 32'd1);
    goto(1'b0, 64, 39);
    check("b_ve_64_39", 32'(b_ve), 32'd0);
    check("b_rgb_64_39", 32'(b_rgb), 32'h000);
    goto(1'b0, 0, 0);
    step(2);
    check("b_fs_count", 32'(b_fs_q.size()), 32'd3);
    if (b_fs_q.size() == 3) begin
      check("b_period_1", 32'(b_fs_q[1] - b_fs_q[0]), 32'd7680);
      check("b_period_2", 32'(b_fs_q[2] - b_fs_q[1]), 32'd7680);
    end

    // ---- instance c: scrolling bars over 9 frames, then reset mid-frame ----
    step(3);
    check("c_rst_rgb", 32'(c_rgb), 32'h000);
    check("c_rst_hsync", 32'(c_hs), 32'd1);
    c_rst = 1'b1;
    step(1);
    check("c_fs_latency1", 32'(c_fs), 32'd1);
    for (int n = 0; n <= 8; n++) begin
      wait_fs_c();
      check($sformatf("c_frame%0d_x0", n), 32'(c_rgb), 32'(bar_tab[n % 8]));
      step(5);
      check($sformatf("c_frame%0d_x5_pos", n), 32'(c_px), 32'd5);
      check($sformatf("c_frame%0d_x5", n), 32'(c_rgb), 32'(bar_tab[(n + 5) % 8]));
    end
    check("c_fs_count", 32'(c_fs_q.size()), 32'd9);
    if (c_fs_q.size() == 9) begin
      check("c_period_first", 32'(c_fs_q[1] - c_fs_q[0]), 32'd55);
      check("c_period_last", 32'(c_fs_q[8] - c_fs_q[7]), 32'd55);
    end
    goto(1'b1, 5, 1);
    c_rst = 1'b0;
    step(2);
    check("c_midrst_px", 32'(c_px), 32'd0);
    check("c_midrst_rgb", 32'(c_rgb), 32'h000);
    check("c_midrst_ve", 32'(c_ve), 32'd0);
    check("c_midrst_fs", 32'(c_fs), 32'd0);
    c_rst = 1'b1;
    step(1);
    check("c_restart_fs", 32'(c_fs), 32'd1);
    check("c_restart_px", 32'(c_px), 32'd0);
    check("c_restart_py", 32'(c_py), 32'd0);
    check("c_restart_ve", 32'(c_ve), 32'd1);
    step(1);
    check("c_restart_fs_width", 32'(c_fs), 32'd0);
    check("c_restart_x1", 32'(c_px), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", n_vec);
    $fatal(1);
  end

endmodule
